// File: rtl/music_sample_sequencer_if.sv
// rtl/music_sample_sequencer_if.sv - ROM fetch and sample handshake bundle for the sequencer
//
// Purpose: groups the sample-ROM address/data pair and the downstream
//          sample valid/ready handshake into one interface.
// Signals:
//   Add           sequencer -> ROM       ROM address (registered in the sequencer)
//   music_content ROM -> sequencer       read data, one cycle after Add is sampled
//   sample        sequencer -> audio     captured sample word
//   sample_valid  sequencer -> audio     sample is offered
//   sample_ready  audio -> sequencer     downstream accepts sample
// Modports: master = sequencer side, slave = ROM/audio side.
interface music_sample_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 17
);
    logic [ADDR_W-1:0] Add;
    logic [DATA_W-1:0] music_content;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output Add,
        output sample,
        output sample_valid,
        input  music_content,
        input  sample_ready
    );

    modport slave (
        input  Add,
        input  sample,
        input  sample_valid,
        output music_content,
        output sample_ready
    );
endinterface

// File: rtl/music_sample_sequencer.sv
// rtl/music_sample_sequencer.sv - sample-ROM playback sequencer with valid/ready output
//
// Purpose: steps the ROM address once per sample period, captures each
//          returned word and offers it downstream; handles start/stop,
//          looping, end-of-clip pulse and sticky underrun.
// Ports:
//   Clk       in   system clock
//   Reset     in   synchronous active-high reset
//   start     in   pulse, begin playback from address 0
//   stop      in   pulse, abort playback (wins over start)
//   bus       master modport: Add, music_content, sample, sample_valid, sample_ready
//   playing   out  high in every state except IDLE
//   done      out  one-cycle pulse when a non-looping clip finishes
//   underrun  out  sticky, a sample period ended before the sample was taken
module music_sample_sequencer #(
    parameter int NUM_SAMPLES = 54832,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 17,
    parameter int TICK_DIV    = 1042,
    parameter int LOOP        = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     stop,
    music_sample_sequencer_if.master bus,
    output logic                     playing,
    output logic                     done,
    output logic                     underrun
);
    localparam int                DIV_W     = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        OFFER,
        WAIT_TICK
    } state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt, div_next;
    logic              tick;
    logic              tick_pending, pending_next;
    logic [ADDR_W-1:0] add_next;
    logic [DATA_W-1:0] sample_next;
    logic              valid_next;
    logic              done_next;
    logic              underrun_next;
    logic              playing_next;

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            div_cnt          <= '0;
            tick_pending     <= 1'b0;
            bus.Add          <= '0;
            bus.sample       <= '0;
            bus.sample_valid <= 1'b0;
            playing          <= 1'b0;
            done             <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            state            <= state_next;
            div_cnt          <= div_next;
            tick_pending     <= pending_next;
            bus.Add          <= add_next;
            bus.sample       <= sample_next;
            bus.sample_valid <= valid_next;
            playing          <= playing_next;
            done             <= done_next;
            underrun         <= underrun_next;
        end
    end

    always_comb begin
        state_next    = state;
        pending_next  = tick_pending;
        add_next      = bus.Add;
        sample_next   = bus.sample;
        valid_next    = bus.sample_valid;
        done_next     = 1'b0;
        underrun_next = underrun;

        if (state == IDLE || tick) begin
            div_next = '0;
        end else begin
            div_next = div_cnt + 1'b1;
        end

        // A period boundary before the handshake completes is remembered
        // once; the address still advances only from WAIT_TICK.
        if (tick && (state inside {FETCH, LATCH, OFFER})) begin
            pending_next  = 1'b1;
            underrun_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    add_next      = '0;
                    underrun_next = 1'b0;
                    div_next      = '0;
                    pending_next  = 1'b0;
                    state_next    = FETCH;
                end
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                sample_next = bus.music_content;
                valid_next  = 1'b1;
                state_next  = OFFER;
            end
            OFFER: begin
                if (bus.sample_valid && bus.sample_ready) begin
                    valid_next = 1'b0;
                    state_next = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick || tick_pending) begin
                    pending_next = 1'b0;
                    if (bus.Add < LAST_ADDR) begin
                        add_next   = bus.Add + 1'b1;
                        state_next = FETCH;
                    end else if (LOOP != 0) begin
                        add_next   = '0;
                        state_next = FETCH;
                    end else begin
                        add_next   = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // stop overrides everything except the sticky underrun flag.
        if (stop) begin
            state_next   = IDLE;
            valid_next   = 1'b0;
            add_next     = '0;
            pending_next = 1'b0;
            done_next    = 1'b0;
            div_next     = '0;
        end

        playing_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_music_sample_sequencer.sv
// tb/tb_music_sample_sequencer.sv - directed self-checking bench for music_sample_sequencer
module tb_music_sample_sequencer;
    localparam logic [16:0] SA = 17'h1A0A1;
    localparam logic [16:0] SB = 17'h0B0B2;
    localparam logic [16:0] SC = 17'h1C0C3;
    localparam logic [16:0] SD = 17'h0D0D4;

    logic Clk;
    logic Reset;
    logic start;
    logic stop;
    logic ready0;
    logic ready1;
    logic playing0, done0, underrun0;
    logic playing1, done1, underrun1;

    int errors;
    int checks;
    int done0_cnt;
    int done1_cnt;

    music_sample_sequencer_if #(.ADDR_W(17), .DATA_W(17)) bus0 ();
    music_sample_sequencer_if #(.ADDR_W(17), .DATA_W(17)) bus1 ();

    music_sample_sequencer #(
        .NUM_SAMPLES(4), .ADDR_W(17), .DATA_W(17), .TICK_DIV(8), .LOOP(0)
    ) dut0 (
        .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .bus(bus0),
        .playing(playing0), .done(done0), .underrun(underrun0)
    );

    music_sample_sequencer #(
        .NUM_SAMPLES(4), .ADDR_W(17), .DATA_W(17), .TICK_DIV(8), .LOOP(1)
    ) dut1 (
        .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .bus(bus1),
        .playing(playing1), .done(done1), .underrun(underrun1)
    );

    function automatic logic [16:0] rom_word(input logic [16:0] a);
        case (a)
            17'd0:   rom_word = SA;
            17'd1:   rom_word = SB;
            17'd2:   rom_word = SC;
            17'd3:   rom_word = SD;
            default: rom_word = 17'h1FFFF;
        endcase
    endfunction

    always @(posedge Clk) begin
        bus0.music_content <= rom_word(bus0.Add);
        bus1.music_content <= rom_word(bus1.Add);
    end

    assign bus0.sample_ready = ready0;
    assign bus1.sample_ready = ready1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        done0_cnt = 0;
        done1_cnt = 0;
    end

    always @(negedge Clk) begin
        if (done0 === 1'b1) done0_cnt <= done0_cnt + 1;
        if (done1 === 1'b1) done1_cnt <= done1_cnt + 1;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        ready0 = 1'b1;
        ready1 = 1'b1;
        step(3);
        chk("rst_add",      32'(bus0.Add), 32'd0);
        chk("rst_sample",   32'(bus0.sample), 32'd0);
        chk("rst_valid",    32'(bus0.sample_valid), 32'd0);
        chk("rst_playing",  32'(playing0), 32'd0);
        chk("rst_done",     32'(done0), 32'd0);
        chk("rst_underrun", 32'(underrun0), 32'd0);
        Reset = 1'b0;
        step(1);
        chk("idle_playing", 32'(playing0), 32'd0);

        // Clip playback, LOOP=0 on dut0 and LOOP=1 on dut1.
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t1_playing_t0", 32'(playing0), 32'd1);
        chk("t1_valid_t0",   32'(bus0.sample_valid), 32'd0);
        step(1);
        chk("t1_valid_t1",   32'(bus0.sample_valid), 32'd0);
        step(1);
        chk("t1_valid_a",    32'(bus0.sample_valid), 32'd1);
        chk("t1_sample_a",   32'(bus0.sample), 32'(SA));
        chk("t1_add_a",      32'(bus0.Add), 32'd0);
        chk("t2_sample_a",   32'(bus1.sample), 32'(SA));
        step(1);
        chk("t1_valid_drop", 32'(bus0.sample_valid), 32'd0);
        step(7);
        chk("t1_valid_b",    32'(bus0.sample_valid), 32'd1);
        chk("t1_sample_b",   32'(bus0.sample), 32'(SB));
        chk("t2_sample_b",   32'(bus1.sample), 32'(SB));
        step(8);
        chk("t1_sample_c",   32'(bus0.sample), 32'(SC));
        chk("t1_add_c",      32'(bus0.Add), 32'd2);
        chk("t2_sample_c",   32'(bus1.sample), 32'(SC));
        step(8);
        chk("t1_sample_d",   32'(bus0.sample), 32'(SD));
        chk("t1_add_d",      32'(bus0.Add), 32'd3);
        chk("t2_sample_d",   32'(bus1.sample), 32'(SD));
        step(5);
        chk("t1_done_early", 32'(done0), 32'd0);
        chk("t1_play_early", 32'(playing0), 32'd1);
        step(1);
        chk("t1_done_pulse", 32'(done0), 32'd1);
        chk("t1_play_end",   32'(playing0), 32'd0);
        chk("t1_add_end",    32'(bus0.Add), 32'd0);
        chk("t2_wrap_add",   32'(bus1.Add), 32'd0);
        chk("t2_wrap_play",  32'(playing1), 32'd1);
        step(1);
        chk("t1_done_once",  32'(done0), 32'd0);
        step(1);
        chk("t2_wrap_a",     32'(bus1.sample), 32'(SA));
        chk("t2_wrap_valid", 32'(bus1.sample_valid), 32'd1);
        step(8);
        chk("t2_wrap_b",     32'(bus1.sample), 32'(SB));
        chk("t2_wrap_addb",  32'(bus1.Add), 32'd1);
        chk("t1_done_count", 32'(done0_cnt), 32'd1);
        chk("t2_done_count", 32'(done1_cnt), 32'd0);
        chk("t1_underrun",   32'(underrun0), 32'd0);
        chk("t2_underrun",   32'(underrun1), 32'd0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t2_stop_play",  32'(playing1), 32'd0);
        chk("t2_stop_valid", 32'(bus1.sample_valid), 32'd0);

        // Downstream stall on sample B, then stop during OFFER of C.
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("t3_sample_a",   32'(bus0.sample), 32'(SA));
        step(7);
        ready0 = 1'b0;
        step(1);
        chk("t3_sample_b",   32'(bus0.sample), 32'(SB));
        chk("t3_urun_pre",   32'(underrun0), 32'd0);
        step(6);
        chk("t3_urun_set",   32'(underrun0), 32'd1);
        chk("t3_hold_valid", 32'(bus0.sample_valid), 32'd1);
        chk("t3_hold_add",   32'(bus0.Add), 32'd1);
        step(5);
        chk("t3_hold_b",     32'(bus0.sample), 32'(SB));
        chk("t3_hold_v2",    32'(bus0.sample_valid), 32'd1);
        ready0 = 1'b1;
        step(1);
        chk("t3_accept",     32'(bus0.sample_valid), 32'd0);
        step(1);
        chk("t3_pend_add",   32'(bus0.Add), 32'd2);
        step(1);
        ready0 = 1'b0;
        step(1);
        chk("t3_sample_c",   32'(bus0.sample), 32'(SC));
        chk("t3_valid_c",    32'(bus0.sample_valid), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t4_stop_valid", 32'(bus0.sample_valid), 32'd0);
        chk("t4_stop_add",   32'(bus0.Add), 32'd0);
        chk("t4_stop_play",  32'(playing0), 32'd0);
        chk("t4_stop_done",  32'(done0), 32'd0);
        chk("t4_urun_keep",  32'(underrun0), 32'd1);
        chk("t4_done_count", 32'(done0_cnt), 32'd1);

        // Restart clears underrun; start during playback is ignored.
        ready0 = 1'b1;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        chk("t4_urun_clr",   32'(underrun0), 32'd0);
        chk("t4_restart",    32'(playing0), 32'd1);
        step(2);
        chk("t4_sample_a",   32'(bus0.sample), 32'(SA));
        chk("t4_add_a",      32'(bus0.Add), 32'd0);
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_ign_add",    32'(bus0.Add), 32'd0);
        chk("t5_ign_play",   32'(playing0), 32'd1);
        step(4);
        chk("t5_sample_b",   32'(bus0.sample), 32'(SB));
        chk("t5_add_b",      32'(bus0.Add), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_both_play",  32'(playing0), 32'd0);
        chk("t5_both_valid", 32'(bus0.sample_valid), 32'd0);
        step(1);
        chk("t5_both_idle",  32'(playing0), 32'd0);

        // Reset in LATCH.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        Reset = 1'b1;
        step(1);
        chk("t6_add",        32'(bus0.Add), 32'd0);
        chk("t6_sample",     32'(bus0.sample), 32'd0);
        chk("t6_valid",      32'(bus0.sample_valid), 32'd0);
        chk("t6_playing",    32'(playing0), 32'd0);
        chk("t6_done",       32'(done0), 32'd0);
        chk("t6_underrun",   32'(underrun0), 32'd0);
        Reset = 1'b0;
        step(1);
        chk("t6_no_leak1",   32'(bus0.sample_valid), 32'd0);
        step(2);
        chk("t6_no_leak2",   32'(bus0.sample_valid), 32'd0);
        chk("t6_idle",       32'(playing0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
